// File: rtl/cv32e40x_fencei_sequencer.sv
// rtl/cv32e40x_fencei_sequencer.sv - fence.i flush sequencer between the controller FSM and the fencei flush pins
module cv32e40x_fencei_sequencer #(
  parameter int unsigned DRAIN_TIMEOUT = 0,
  parameter int unsigned ACK_TIMEOUT   = 0,
  parameter int unsigned CNT_W         = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  input  logic kill_i,
  input  logic lsu_busy_i,
  input  logic lsu_bus_busy_i,
  input  logic fencei_flush_ack_i,
  output logic fencei_flush_req_o,
  output logic halt_o,
  output logic done_o,
  output logic err_o,
  output logic busy_o
);

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    REQ,
    ERR_WAIT,
    DONE
  } state_e;

  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ACK_LAST   = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  if ((DRAIN_TIMEOUT >> CNT_W) != 0 || (ACK_TIMEOUT >> CNT_W) != 0) begin : g_param_chk
    $error("timeout parameters must fit in CNT_W bits");
  end

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             err_d;

  // One counter serves both waits; it is cleared on entry to DRAIN and REQ.
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i && !kill_i) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end
      end
      DRAIN: begin
        if (kill_i) begin
          state_d = IDLE;
        end else if (!lsu_busy_i && !lsu_bus_busy_i) begin
          state_d = REQ;
          cnt_d   = '0;
        end else if (DRAIN_TIMEOUT != 0 && cnt_q == DRAIN_LAST) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      // Once raised, the request is only retired by an ack; kill_i has no say here.
      REQ: begin
        if (fencei_flush_ack_i) begin
          state_d = DONE;
        end else if (ACK_TIMEOUT != 0 && cnt_q == ACK_LAST) begin
          state_d = ERR_WAIT;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ERR_WAIT: begin
        if (fencei_flush_ack_i) begin
          state_d = IDLE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q            <= IDLE;
      cnt_q              <= '0;
      fencei_flush_req_o <= 1'b0;
      halt_o             <= 1'b0;
      done_o             <= 1'b0;
      err_o              <= 1'b0;
      busy_o             <= 1'b0;
    end else begin
      state_q            <= state_d;
      cnt_q              <= cnt_d;
      fencei_flush_req_o <= (state_d == REQ) || (state_d == ERR_WAIT);
      halt_o             <= (state_d != IDLE);
      done_o             <= (state_d == DONE);
      err_o              <= err_d;
      busy_o             <= (state_d != IDLE);
    end
  end

  a_req_hold: assert property (@(posedge clk) disable iff (rst)
    fencei_flush_req_o && !fencei_flush_ack_i |=> fencei_flush_req_o);

  a_done_err_excl: assert property (@(posedge clk) disable iff (rst)
    !(done_o && err_o));

  a_halt_when_busy: assert property (@(posedge clk) disable iff (rst)
    busy_o |-> halt_o);

  a_start_when_idle: assert property (@(posedge clk) disable iff (rst)
    start_i |-> !busy_o);

endmodule
